// File: rtl/sat_serial_tx_if.sv
// ---------------------------------------------------------------------------
// sat_serial_tx_if
//   Sample-side valid/ready handshake of the saturating serial transmitter.
//   Parameters DW/DWA must match the attached sat_serial_tx instance.
//
//   in_valid  source -> tx   sample present
//   in_ready  tx -> source   transmitter accepts the sample this cycle
//   in_data   source -> tx   signed [DW+DWA:0] wide sample
//
//   master : the sample source
//   slave  : the transmitter
// ---------------------------------------------------------------------------
interface sat_serial_tx_if #(
    parameter int DW  = 10,
    parameter int DWA = 11
);
    logic                   in_valid;
    logic                   in_ready;
    logic signed [DW+DWA:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/sat_serial_tx.sv
// ---------------------------------------------------------------------------
// sat_serial_tx
//   Accepts wide signed samples, saturates each one to a (DW+1)-bit signed
//   word and transmits it MSB-first on a one-bit line, the first bit marked
//   by ser_sync. GAP idle cycles separate frames; with GAP == 0 a new sample
//   may be taken on the last bit cycle so frames run back-to-back.
//
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_if      sample handshake (slave side): in_valid, in_ready, in_data
//   ser_valid  ser_data carries a frame bit
//   ser_sync   high with the MSB of each frame
//   ser_data   serial bit, MSB first, 0 when ser_valid is low
//   sat_flag   registered; high for the whole frame when the word was clamped
//   busy       frame in progress or gap counting
// ---------------------------------------------------------------------------
module sat_serial_tx #(
    parameter int DW  = 10,
    parameter int DWA = 11,
    parameter int GAP = 1
) (
    input  logic            clk,
    input  logic            rst,
    sat_serial_tx_if.slave  in_if,
    output logic            ser_valid,
    output logic            ser_sync,
    output logic            ser_data,
    output logic            sat_flag,
    output logic            busy
);
    localparam int IW = DW + DWA + 1;
    localparam int CW = $clog2(DW + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [CW-1:0] CNT_TOP = CW'(DW);
    localparam logic [GW-1:0] GAP_TOP = GW'((GAP > 0) ? GAP - 1 : 0);

    // Saturation bounds, sign-extended to the full input width
    localparam logic signed [IW-1:0] MAXV = {{(DWA + 1){1'b0}}, {DW{1'b1}}};
    localparam logic signed [IW-1:0] MINV = {{(DWA + 1){1'b1}}, {DW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [GW-1:0] gcnt, gcnt_n;
    logic [DW:0]   sreg, sreg_n;
    logic          sat_q, sat_n;
    logic          ready;

    logic          clamp_hi, clamp_lo;
    logic [DW:0]   sat_word;

    always_comb begin
        clamp_hi = $signed(in_if.in_data) > $signed(MAXV);
        clamp_lo = $signed(in_if.in_data) < $signed(MINV);
        if (clamp_hi) begin
            sat_word = {1'b0, {DW{1'b1}}};
        end else if (clamp_lo) begin
            sat_word = {1'b1, {DW{1'b0}}};
        end else begin
            sat_word = in_if.in_data[DW:0];
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        gcnt_n    = gcnt;
        sreg_n    = sreg;
        sat_n     = sat_q;
        ready     = 1'b0;
        ser_valid = 1'b0;
        ser_sync  = 1'b0;
        ser_data  = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (in_if.in_valid) begin
                    state_n = ST_SHIFT;
                    cnt_n   = CNT_TOP;
                    sreg_n  = sat_word;
                    sat_n   = clamp_hi | clamp_lo;
                end
            end
            ST_SHIFT: begin
                ser_valid = 1'b1;
                ser_data  = sreg[DW];
                ser_sync  = (cnt == CNT_TOP);
                sreg_n    = {sreg[DW-1:0], 1'b0};
                if (cnt == '0) begin
                    if (GAP > 0) begin
                        state_n = ST_GAP;
                        gcnt_n  = GAP_TOP;
                    end else begin
                        // Last bit with no gap: a new sample may be taken now
                        ready = 1'b1;
                        if (in_if.in_valid) begin
                            cnt_n  = CNT_TOP;
                            sreg_n = sat_word;
                            sat_n  = clamp_hi | clamp_lo;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_GAP: begin
                if (gcnt == '0) begin
                    state_n = ST_IDLE;
                end else begin
                    gcnt_n = gcnt - 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            gcnt  <= '0;
            sreg  <= '0;
            sat_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            gcnt  <= gcnt_n;
            sreg  <= sreg_n;
            sat_q <= sat_n;
        end
    end

    assign in_if.in_ready = ready;
    assign sat_flag       = sat_q;
    assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_sat_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_sat_serial_tx
//   Two transmitters (GAP=1 and GAP=0) share one stimulus stream. Each has a
//   queue-based model of the expected serial bits, gap cycles and clamp flag,
//   plus a scoreboard that rebuilds words from the serial line.
// ---------------------------------------------------------------------------
module tb_sat_serial_tx;
    localparam int DW  = 10;
    localparam int DWA = 11;
    localparam int IW  = DW + DWA + 1;
    localparam int GAPV [2] = '{1, 0};

    logic clk = 1'b0;
    logic rst;
    logic drv_valid;
    logic signed [IW-1:0] drv_data;

    logic sv [2];
    logic ss [2];
    logic sd [2];
    logic sf [2];
    logic bz [2];
    logic rd [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sat_serial_tx_if #(.DW(DW), .DWA(DWA)) if0 ();
    sat_serial_tx_if #(.DW(DW), .DWA(DWA)) if1 ();

    assign if0.in_valid = drv_valid;
    assign if0.in_data  = drv_data;
    assign if1.in_valid = drv_valid;
    assign if1.in_data  = drv_data;
    assign rd[0] = if0.in_ready;
    assign rd[1] = if1.in_ready;

    sat_serial_tx #(.DW(DW), .DWA(DWA), .GAP(1)) dut0 (
        .clk(clk), .rst(rst), .in_if(if0),
        .ser_valid(sv[0]), .ser_sync(ss[0]), .ser_data(sd[0]),
        .sat_flag(sf[0]), .busy(bz[0])
    );

    sat_serial_tx #(.DW(DW), .DWA(DWA), .GAP(0)) dut1 (
        .clk(clk), .rst(rst), .in_if(if1),
        .ser_valid(sv[1]), .ser_sync(ss[1]), .ser_data(sd[1]),
        .sat_flag(sf[1]), .busy(bz[1])
    );

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s[dut%0d] got=%0h want=%0h at %0t", name, k, act, want, $time);
        end
    endtask

    function automatic logic [DW:0] model_word(input longint v, output bit clamped);
        longint hi;
        longint lo;
        longint r;
        hi = (longint'(1) <<< DW) - 1;
        lo = -(longint'(1) <<< DW);
        r = v;
        clamped = 1'b0;
        if (v > hi) begin
            r = hi;
            clamped = 1'b1;
        end else if (v < lo) begin
            r = lo;
            clamped = 1'b1;
        end
        return r[DW:0];
    endfunction

    // Model state per instance
    bit          bq [2][$];      // bits still to send in the current frame
    int          gl [2];         // gap cycles still to run
    bit          sm [2];         // expected sat_flag
    logic [DW:0] wq [2][$];      // accepted words not yet rebuilt
    int          nacc [2];
    logic [DW:0] acc [2];
    int          an [2];
    logic [DW:0] last_word [2];
    bit          last_sat [2];
    bit          armed = 1'b0;

    always @(negedge clk) begin
        bit ev, ed, es, er, eb, take, cl;
        logic [DW:0] w, nw;
        for (int k = 0; k < 2; k++) begin
            ev = bq[k].size() > 0;
            ed = ev ? bq[k][0] : 1'b0;
            es = bq[k].size() == DW + 1;
            er = (bq[k].size() == 0 && gl[k] == 0) || (GAPV[k] == 0 && bq[k].size() == 1);
            eb = bq[k].size() > 0 || gl[k] > 0;
            if (armed) begin
                chk("ser_valid", k, 32'(sv[k]), 32'(ev));
                chk("ser_data", k, 32'(sd[k]), 32'(ed));
                chk("ser_sync", k, 32'(ss[k]), 32'(es));
                chk("in_ready", k, 32'(rd[k]), 32'(er));
                chk("busy", k, 32'(bz[k]), 32'(eb));
                chk("sat_flag", k, 32'(sf[k]), 32'(sm[k]));
                // Rebuild words from the serial line
                if (sv[k] === 1'b1) begin
                    if (ss[k] === 1'b1) begin
                        nw = {{DW{1'b0}}, sd[k]};
                        an[k] = 1;
                    end else begin
                        nw = {acc[k][DW-1:0], sd[k]};
                        an[k]++;
                    end
                    acc[k] = nw;
                    if (an[k] == DW + 1) begin
                        if (wq[k].size() == 0) begin
                            chk("extra_frame", k, 32'(nw), 32'hFFFF_FFFF);
                        end else begin
                            chk("frame_word", k, 32'(nw), 32'(wq[k][0]));
                            void'(wq[k].pop_front());
                        end
                        last_word[k] = nw;
                        last_sat[k]  = sf[k];
                        an[k] = 0;
                    end
                end
            end
            // Advance the model to the next cycle
            if (rst) begin
                bq[k].delete();
                wq[k].delete();
                gl[k] = 0;
                sm[k] = 1'b0;
                an[k] = 0;
            end else if (armed) begin
                take = drv_valid && er;
                if (bq[k].size() > 0) begin
                    void'(bq[k].pop_front());
                    if (bq[k].size() == 0 && GAPV[k] > 0) gl[k] = GAPV[k];
                end else if (gl[k] > 0) begin
                    gl[k]--;
                end
                if (take) begin
                    w = model_word(longint'(drv_data), cl);
                    sm[k] = cl;
                    wq[k].push_back(w);
                    for (int i = DW; i >= 0; i--) bq[k].push_back(w[i]);
                    nacc[k]++;
                end
            end
        end
        if (rst) armed = 1'b1;
    end

    task automatic send(input longint v);
        int base;
        int t;
        base = nacc[0];
        drv_valid = 1'b1;
        drv_data  = v[IW-1:0];
        t = 0;
        while (nacc[0] == base && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        drv_valid = 1'b0;
        if (t >= 100) chk("accept_timeout", 0, 32'(t), 32'd0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((bq[0].size() != 0 || gl[0] != 0 || wq[0].size() != 0 ||
                bq[1].size() != 0 || gl[1] != 0 || wq[1].size() != 0) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) chk("idle_timeout", 0, 32'(t), 32'd0);
    endtask

    task automatic word_case(input longint v, input logic [DW:0] want_w, input bit want_s);
        send(v);
        wait_idle();
        chk("lit_word", 0, 32'(last_word[0]), 32'(want_w));
        chk("lit_sat", 0, 32'(last_sat[0]), 32'(want_s));
    endtask

    bit vrec [60];
    bit srec [60];

    initial begin
        int base, first, run, nsync, cyc;
        longint r;
        for (int k = 0; k < 2; k++) begin
            gl[k] = 0; sm[k] = 0; nacc[k] = 0; an[k] = 0;
            acc[k] = '0; last_word[k] = '0; last_sat[k] = 0;
        end
        rst = 1'b1;
        drv_valid = 1'b0;
        drv_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_ready", 0, 32'(rd[0]), 32'd1);
        chk("rst_valid", 0, 32'(sv[0]), 32'd0);
        chk("rst_busy", 0, 32'(bz[0]), 32'd0);
        @(posedge clk); #1;

        // Directed words, including the clamp boundaries
        word_case(5,     11'h005, 1'b0);
        word_case(5000,  11'h3FF, 1'b1);
        word_case(-5000, 11'h400, 1'b1);
        word_case(-1,    11'h7FF, 1'b0);
        word_case(1023,  11'h3FF, 1'b0);
        word_case(-1024, 11'h400, 1'b0);
        word_case(1024,  11'h3FF, 1'b1);
        word_case(-1025, 11'h400, 1'b1);

        // Back-to-back on the GAP=0 instance with in_valid held high
        base = nacc[1];
        drv_valid = 1'b1;
        drv_data  = IW'(300);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            vrec[c] = sv[1];
            srec[c] = ss[1];
            @(posedge clk); #1;
            if (nacc[1] - base >= 3) drv_valid = 1'b0;
        end
        drv_valid = 1'b0;
        first = -1; run = 0; nsync = 0;
        for (int c = 0; c < 60; c++) begin
            if (vrec[c] && first < 0) first = c;
            if (srec[c]) nsync++;
        end
        if (first >= 0) begin
            for (int c = first; c < 60 && vrec[c]; c++) run++;
        end
        chk("b2b_run", 1, 32'(run), 32'd33);
        chk("b2b_nsync", 1, 32'(nsync), 32'd3);
        chk("b2b_sync11", 1, (first >= 0 && first + 22 < 60) ? 32'({srec[first], srec[first + 11], srec[first + 22]}) : 32'd0, 32'd7);
        wait_idle();

        // Reset during bit 4 of a clamped frame
        send(5000);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("pre_rst_sat", 0, 32'(sf[0]), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 0, 32'(sv[0]), 32'd0);
        chk("post_rst_ready", 0, 32'(rd[0]), 32'd1);
        chk("post_rst_sat", 0, 32'(sf[0]), 32'd0);
        @(posedge clk); #1;
        word_case(-5, 11'h7FB, 1'b0);

        // Random valid and data over 1000 accepted samples
        base = nacc[0];
        cyc = 0;
        while (nacc[0] - base < 1000 && cyc < 60000) begin
            drv_valid = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 0) r = longint'($urandom_range(0, 4400)) - 2200;
            else r = longint'($urandom_range(0, 8000000)) - 4000000;
            drv_data = r[IW-1:0];
            @(posedge clk); #1;
            cyc++;
        end
        drv_valid = 1'b0;
        chk("rand_count", 0, 32'(nacc[0] - base), 32'd1000);
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("lost_frames", k, 32'(wq[k].size()), 32'd0);
            chk("partial_word", k, 32'(an[k]), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
